// File: rtl/xphy_mdio_pkg.sv
// xphy_mdio_pkg: shared Clause-45 MDIO opcodes, device/register constants and sequencer states
package xphy_mdio_pkg;
    localparam logic [1:0] MDIO_OP_ADDR = 2'b00;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b11;
    localparam logic [4:0] DEVAD_PMA = 5'd1;
    localparam logic [4:0] DEVAD_PCS = 5'd3;
    localparam logic [15:0] REG_CTRL = 16'h0000;
    localparam logic [15:0] REG_STAT = 16'h0001;
    typedef enum logic [1:0] {RESET_IDLE, CFG, POLL, POLL_WAIT} seq_state_t;
endpackage

// File: rtl/xphy_mdio_frame.sv
// xphy_mdio_frame: single MDIO transaction engine (MDC, 64-bit frame shift, TA check, read capture)
module xphy_mdio_frame
    import xphy_mdio_pkg::*;
#(
    parameter int MDC_DIV = 24
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  prtad,
    input  logic [4:0]  devad,
    input  logic [15:0] data,
    input  logic        mdio_out,
    input  logic        mdio_tri,
    output logic        mdc,
    output logic        mdio_in,
    output logic        busy,
    output logic        done,
    output logic        rvalid,
    output logic [15:0] rdata,
    output logic        ta_err
);
    localparam int PW = $clog2(MDC_DIV);
    localparam logic [PW-1:0] PH_MAX = PW'(MDC_DIV - 1);

    logic          active, mdc_r, rd, ta_bad, is_rd, bit_end, last;
    logic [PW-1:0] ph;
    logic [6:0]    bitc;
    logic [63:0]   sr, frame;
    logic [15:0]   rd_sr;

    assign is_rd = op == MDIO_OP_RD;
    assign frame = {32'hFFFF_FFFF, 2'b00, op, prtad, devad, is_rd ? 2'b11 : 2'b10, is_rd ? 16'hFFFF : data};
    assign bit_end = active && mdc_r && ph == PH_MAX;
    assign last = bit_end && bitc == 7'd64;
    assign mdc = mdc_r;
    assign mdio_in = sr[63];
    assign busy = active;
    assign done = last;
    assign rvalid = bit_end && rd && bitc == 7'd63;
    assign rdata = {rd_sr[14:0], mdio_out};
    assign ta_err = ta_bad;

    // bit timing and shift: host bit changes entering low phase, PHY sampled at end of high phase
    always_ff @(posedge clk156) begin
        if (reset) begin
            active <= 1'b0;
            mdc_r <= 1'b0;
            ph <= '0;
            bitc <= '0;
            sr <= '1;
            rd_sr <= '0;
            rd <= 1'b0;
            ta_bad <= 1'b0;
        end else if (start && (!active || last)) begin
            active <= 1'b1;
            mdc_r <= 1'b0;
            ph <= '0;
            bitc <= '0;
            sr <= frame;
            rd <= is_rd;
        end else if (active) begin
            ph <= (ph == PH_MAX) ? '0 : ph + 1'b1;
            if (ph == PH_MAX) mdc_r <= ~mdc_r;
            if (bit_end) begin
                sr <= {sr[62:0], 1'b1};
                bitc <= last ? bitc : bitc + 7'd1;
                active <= !last;
                if (rd && bitc == 7'd47) ta_bad <= mdio_tri | mdio_out;
                if (rd && bitc[6:4] == 3'b011) rd_sr <= {rd_sr[14:0], mdio_out};
            end
        end
    end
endmodule

// File: rtl/xphy_mdio_ctrl.sv
// xphy_mdio_ctrl: PHY bring-up write sequence, periodic PCS status poll and link status
module xphy_mdio_ctrl
    import xphy_mdio_pkg::*;
#(
    parameter int MDC_DIV = 24,
    parameter int POLL_INTERVAL = 156250
) (
    input  logic        clk156,
    input  logic        reset,
    input  logic [4:0]  prtad,
    input  logic        mdio_out,
    input  logic        mdio_tri,
    input  logic        cfg_start,
    output logic        mdc,
    output logic        mdio_in,
    output logic        busy,
    output logic        cfg_done,
    output logic        link_up,
    output logic [15:0] pcs_status,
    output logic        err
);
    localparam int TW = $clog2(POLL_INTERVAL);
    localparam logic [TW-1:0] T_MAX = TW'(POLL_INTERVAL - 1);

    seq_state_t    state, state_n;
    logic [1:0]    step, step_n, op;
    logic [4:0]    devad;
    logic [15:0]   data, rdata;
    logic [TW-1:0] timer;
    logic          cfg_req, req, free, launch, accept, fin_cfg, poll_start, timer_up, poll_rest;
    logic          done, rvalid, ta_err;

    assign req = cfg_start || cfg_req;
    assign free = !busy || done;
    assign timer_up = timer == T_MAX;
    assign poll_rest = busy && step[0] && !timer_up;
    assign poll_start = launch && state_n == POLL && step_n == 2'd0;
    assign op = (state_n == POLL) ? (step_n[0] ? MDIO_OP_RD : MDIO_OP_ADDR) : (step_n[0] ? MDIO_OP_WR : MDIO_OP_ADDR);
    assign devad = (state_n == POLL || step_n[1]) ? DEVAD_PCS : DEVAD_PMA;
    assign data = (state_n == POLL) ? REG_STAT : (step_n[0] ? 16'h0000 : REG_CTRL);

    // step sequencer: next transaction is launched on the engine's last cycle so frames run back to back
    always_comb begin
        state_n = state;
        step_n = step;
        launch = 1'b0;
        accept = 1'b0;
        fin_cfg = 1'b0;
        if (state == RESET_IDLE) begin
            state_n = CFG;
            step_n = 2'd0;
        end else if (free && req) begin
            state_n = CFG;
            step_n = 2'd0;
            launch = 1'b1;
            accept = 1'b1;
        end else if (free) begin
            case (state)
                CFG: begin
                    launch = 1'b1;
                    fin_cfg = busy && step == 2'd3;
                    state_n = fin_cfg ? POLL : CFG;
                    step_n = busy ? step + 2'd1 : step;
                end
                POLL: begin
                    launch = !poll_rest;
                    state_n = poll_rest ? POLL_WAIT : POLL;
                    step_n = busy ? {1'b0, ~step[0]} : step;
                end
                POLL_WAIT: begin
                    launch = timer_up;
                    state_n = timer_up ? POLL : POLL_WAIT;
                    step_n = 2'd0;
                end
                default: ;
            endcase
        end
    end

    // sequencer state register
    always_ff @(posedge clk156) begin
        if (reset) begin
            state <= RESET_IDLE;
            step <= 2'd0;
        end else begin
            state <= state_n;
            step <= step_n;
        end
    end

    // pending reconfiguration request and poll-start timer
    always_ff @(posedge clk156) begin
        if (reset) begin
            cfg_req <= 1'b0;
            timer <= '0;
        end else begin
            cfg_req <= (accept || state == RESET_IDLE) ? 1'b0 : (cfg_req || cfg_start);
            timer <= poll_start ? '0 : (timer_up ? timer : timer + 1'b1);
        end
    end

    // published status: cfg_done, sticky TA error, last good PCS status
    always_ff @(posedge clk156) begin
        if (reset) begin
            cfg_done <= 1'b0;
            err <= 1'b0;
            link_up <= 1'b0;
            pcs_status <= '0;
        end else begin
            if (accept) begin
                cfg_done <= 1'b0;
                err <= 1'b0;
            end else if (fin_cfg) begin
                cfg_done <= 1'b1;
            end
            if (rvalid && ta_err) begin
                err <= 1'b1;
                link_up <= 1'b0;
            end else if (rvalid) begin
                pcs_status <= rdata;
                link_up <= rdata[2];
            end
        end
    end

    xphy_mdio_frame #(.MDC_DIV(MDC_DIV)) u_frame (
        .clk156   (clk156),
        .reset    (reset),
        .start    (launch),
        .op       (op),
        .prtad    (prtad),
        .devad    (devad),
        .data     (data),
        .mdio_out (mdio_out),
        .mdio_tri (mdio_tri),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .busy     (busy),
        .done     (done),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ta_err   (ta_err)
    );
endmodule

// File: tb/tb_xphy_mdio_ctrl.sv
// tb_xphy_mdio_ctrl: scoreboard bench with a Clause-45 PHY model for xphy_mdio_ctrl
module tb_xphy_mdio_ctrl;
    localparam logic [63:0] C0 = 64'hFFFF_FFFF_0286_0000;
    localparam logic [63:0] C1 = 64'hFFFF_FFFF_1286_0000;
    localparam logic [63:0] C2 = 64'hFFFF_FFFF_028E_0000;
    localparam logic [63:0] C3 = 64'hFFFF_FFFF_128E_0000;
    localparam logic [63:0] P0 = 64'hFFFF_FFFF_028E_0001;
    localparam logic [63:0] P1 = 64'hFFFF_FFFF_328F_FFFF;

    logic        clk156 = 1'b0, reset, cfg_start, mdio_out, mdio_tri;
    logic [4:0]  prtad;
    logic        mdc, mdio_in, busy, cfg_done, link_up, err;
    logic [15:0] pcs_status;
    logic        phy_ack, mon_en;
    logic [15:0] phy_data;
    logic [63:0] exp_q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0;

    xphy_mdio_ctrl #(.MDC_DIV(2), .POLL_INTERVAL(2000)) dut (
        .clk156     (clk156),
        .reset      (reset),
        .prtad      (prtad),
        .mdio_out   (mdio_out),
        .mdio_tri   (mdio_tri),
        .cfg_start  (cfg_start),
        .mdc        (mdc),
        .mdio_in    (mdio_in),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .link_up    (link_up),
        .pcs_status (pcs_status),
        .err        (err)
    );

    always #5 clk156 = ~clk156;

    initial forever begin
        @(posedge clk156);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_cfg();
        exp_q.push_back(C0);
        exp_q.push_back(C1);
        exp_q.push_back(C2);
        exp_q.push_back(C3);
    endtask

    task automatic chk_reset(input string name);
        chk(name, {mdc, mdio_in, busy, cfg_done, link_up, err, pcs_status},
            {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    endtask

    // PHY model and frame monitor: captures host bits on MDC rise, answers read TA/data
    initial begin
        int bc;
        logic [63:0] sh;
        logic rd, drv;
        bc = 0;
        rd = 1'b0;
        sh = '0;
        mdio_out = 1'b1;
        mdio_tri = 1'b1;
        forever begin
            @(posedge mdc or posedge reset);
            if (reset) begin
                bc = 0;
                rd = 1'b0;
                mdio_out = 1'b1;
                mdio_tri = 1'b1;
            end else begin
                sh = {sh[62:0], mdio_in};
                if (bc == 35) rd = sh[1:0] == 2'b11;
                drv = rd && phy_ack && bc >= 47 && bc <= 63;
                mdio_tri = !drv;
                mdio_out = !drv ? 1'b1 : (bc == 47 ? 1'b0 : phy_data[4'(63 - bc)]);
                if (bc == 63 && mon_en) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL frame: got unexpected %h expected none", sh);
                    end else begin
                        chk("frame", sh, exp_q.pop_front());
                    end
                end
                bc = (bc == 64) ? 0 : bc + 1;
            end
        end
    end

    // release reset, check first bit timing and cfg_done latency; returns the P0 launch cycle
    task automatic startup(input string tag, output int td);
        int c0;
        logic [7:0] pat;
        push_cfg();
        exp_q.push_back(P0);
        exp_q.push_back(P1);
        reset = 1'b0;
        c0 = cyc;
        @(negedge clk156);
        chk({tag, "_busy_k1"}, 64'(busy), 64'd0);
        @(negedge clk156);
        chk({tag, "_busy_k2"}, 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            pat[7 - i] = mdc;
            @(negedge clk156);
        end
        chk({tag, "_mdc_pattern"}, 64'(pat), 64'h33);
        for (int i = 0; i < 2000 && !cfg_done; i++) @(negedge clk156);
        chk({tag, "_cfg_done_latency"}, 64'(cyc - c0 - 1), 64'd1041);
        chk({tag, "_p0_busy"}, 64'(busy), 64'd1);
        td = cyc;
    endtask

    initial begin
        int td, tp, ta, a, b;
        reset = 1'b1;
        cfg_start = 1'b0;
        prtad = 5'd5;
        phy_ack = 1'b1;
        phy_data = 16'h0004;
        mon_en = 1'b1;
        repeat (3) @(negedge clk156);
        chk_reset("reset_values");

        startup("s1", td);

        repeat (530) @(negedge clk156);
        chk("s3_status", {link_up, err, pcs_status}, {1'b1, 1'b0, 16'h0004});
        exp_q.push_back(P0);
        exp_q.push_back(P1);
        for (int i = 0; i < 3000 && !busy; i++) @(negedge clk156);
        chk("s3_poll_period", 64'(cyc - td), 64'd2000);
        tp = cyc;

        repeat (530) @(negedge clk156);
        chk("s4_status_before", {link_up, err, pcs_status}, {1'b1, 1'b0, 16'h0004});
        phy_ack = 1'b0;
        exp_q.push_back(P0);
        exp_q.push_back(P1);
        for (int i = 0; i < 3000 && !busy; i++) @(negedge clk156);
        chk("s4_poll_period", 64'(cyc - tp), 64'd2000);
        repeat (530) @(negedge clk156);
        chk("s4_ta_fail", {link_up, err, pcs_status}, {1'b0, 1'b1, 16'h0004});
        phy_ack = 1'b1;
        cfg_start = 1'b1;
        push_cfg();
        exp_q.push_back(P0);
        push_cfg();
        exp_q.push_back(P0);
        @(negedge clk156);
        cfg_start = 1'b0;
        chk("s4_cfg_start_clear", {err, cfg_done, busy}, {1'b0, 1'b0, 1'b1});
        ta = cyc;
        for (int i = 0; i < 2000 && !cfg_done; i++) @(negedge clk156);
        chk("s4_recfg_latency", 64'(cyc - ta), 64'd1040);
        a = cyc;

        repeat (20) @(negedge clk156);
        cfg_start = 1'b1;
        @(negedge clk156);
        cfg_start = 1'b0;
        repeat (39) @(negedge clk156);
        cfg_start = 1'b1;
        @(negedge clk156);
        cfg_start = 1'b0;
        for (int i = 0; i < 300 && cyc < a + 259; i++) @(negedge clk156);
        chk("s5_done_during_p0", 64'(cfg_done), 64'd1);
        @(negedge clk156);
        chk("s5_accept", {cfg_done, busy}, {1'b0, 1'b1});
        b = cyc;
        chk("s5_accept_cycle", 64'(b - a), 64'd260);
        for (int i = 0; i < 2000 && !cfg_done; i++) @(negedge clk156);
        chk("s5_rerise_latency", 64'(cyc - b), 64'd1040);
        a = cyc;

        for (int i = 0; i < 600 && cyc < a + 421; i++) @(negedge clk156);
        reset = 1'b1;
        @(negedge clk156);
        chk_reset("s6_reset_midframe");
        chk("s6_queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk156);
        startup("s6", td);
        repeat (530) @(negedge clk156);
        chk("s6_status", {link_up, err, pcs_status}, {1'b1, 1'b0, 16'h0004});
        chk("final_queue_drained", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
